// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with single-cycle arith/logic/shift ops and a shift-add MULU.
// Define ALU_MC_DIV_EN to add the restoring DIVU (opcode 0E); otherwise 0E passes a through.

module alu_mc #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [5:0]       i_ctrl,
  input  logic [WIDTH-1:0] i_data_a,
  input  logic [WIDTH-1:0] i_data_b,
  input  logic             i_carry,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic [WIDTH-1:0] o_data_hi,
  output logic [3:0]       o_flag
);

  localparam int unsigned     CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [5:0] OP_ADD  = 6'h0A;
  localparam logic [5:0] OP_SUB  = 6'h09;
  localparam logic [5:0] OP_INC  = 6'h1B;
  localparam logic [5:0] OP_DEC  = 6'h08;
  localparam logic [5:0] OP_AND  = 6'h06;
  localparam logic [5:0] OP_OR   = 6'h12;
  localparam logic [5:0] OP_NOT  = 6'h14;
  localparam logic [5:0] OP_XOR  = 6'h16;
  localparam logic [5:0] OP_SHL  = 6'h20;
  localparam logic [5:0] OP_SHR  = 6'h30;
  localparam logic [5:0] OP_SAL  = 6'h24;
  localparam logic [5:0] OP_SAR  = 6'h34;
  localparam logic [5:0] OP_ROL  = 6'h22;
  localparam logic [5:0] OP_ROR  = 6'h32;
  localparam logic [5:0] OP_ADC  = 6'h0B;
  localparam logic [5:0] OP_SBB  = 6'h0D;
  localparam logic [5:0] OP_MULU = 6'h0C;
`ifdef ALU_MC_DIV_EN
  localparam logic [5:0] OP_DIVU = 6'h0E;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   mc_hi_q, mc_hi_d;
  logic [WIDTH-1:0]   mc_lo_q, mc_lo_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [WIDTH-1:0]   data_hi_q, data_hi_d;
  logic [3:0]         flag_q, flag_d;
  logic               valid_q, valid_d;
`ifdef ALU_MC_DIV_EN
  logic               is_div_q, is_div_d;
`endif

  logic               accept;
  logic [WIDTH:0]     ext_a, ext_b, arith;
  logic               a_msb, b_msb;
  logic [WIDTH-1:0]   sc_res;
  logic               sc_c, sc_v;

  assign ext_a = {1'b0, i_data_a};
  assign ext_b = {1'b0, i_data_b};
  assign a_msb = i_data_a[WIDTH-1];
  assign b_msb = i_data_b[WIDTH-1];

  // Single-cycle result and C/V; arithmetic is done at WIDTH+1 bits so bit WIDTH is carry/borrow.
  always_comb begin : sc_alu
    arith  = '0;
    sc_res = i_data_a;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (i_ctrl)
      OP_ADD, OP_ADC: begin
        arith  = ext_a + ext_b + ((i_ctrl == OP_ADC) ? (WIDTH+1)'(i_carry) : (WIDTH+1)'(0));
        sc_res = arith[WIDTH-1:0];
        sc_c   = arith[WIDTH];
        sc_v   = (a_msb == b_msb) && (arith[WIDTH-1] != a_msb);
      end
      OP_SUB, OP_SBB: begin
        arith  = ext_a - ext_b - ((i_ctrl == OP_SBB) ? (WIDTH+1)'(i_carry) : (WIDTH+1)'(0));
        sc_res = arith[WIDTH-1:0];
        sc_c   = arith[WIDTH];
        sc_v   = (a_msb != b_msb) && (arith[WIDTH-1] != a_msb);
      end
      OP_INC: begin
        arith  = ext_a + (WIDTH+1)'(1);
        sc_res = arith[WIDTH-1:0];
        sc_c   = arith[WIDTH];
        sc_v   = !a_msb && arith[WIDTH-1];
      end
      OP_DEC: begin
        arith  = ext_a - (WIDTH+1)'(1);
        sc_res = arith[WIDTH-1:0];
        sc_c   = arith[WIDTH];
        sc_v   = a_msb && !arith[WIDTH-1];
      end
      OP_AND: sc_res = i_data_a & i_data_b;
      OP_OR:  sc_res = i_data_a | i_data_b;
      OP_NOT: sc_res = ~i_data_a;
      OP_XOR: sc_res = i_data_a ^ i_data_b;
      OP_SHL: begin
        sc_res = {i_data_a[WIDTH-2:0], 1'b0};
        sc_c   = a_msb;
      end
      OP_SAL: begin
        sc_res = {i_data_a[WIDTH-2:0], 1'b0};
        sc_c   = a_msb;
        sc_v   = a_msb ^ i_data_a[WIDTH-2];
      end
      OP_SHR: begin
        sc_res = {1'b0, i_data_a[WIDTH-1:1]};
        sc_c   = i_data_a[0];
      end
      OP_SAR: begin
        sc_res = {a_msb, i_data_a[WIDTH-1:1]};
        sc_c   = i_data_a[0];
      end
      OP_ROL: begin
        sc_res = {i_data_a[WIDTH-2:0], a_msb};
        sc_c   = a_msb;
      end
      OP_ROR: begin
        sc_res = {i_data_a[0], i_data_a[WIDTH-1:1]};
        sc_c   = i_data_a[0];
      end
      default: ;
    endcase
  end

  // One shift-add multiply iteration: {hi,lo} holds partial product over the remaining multiplier.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_n, mul_lo_n;

  always_comb begin : mul_step
    mul_sum  = {1'b0, mc_hi_q} + (mc_lo_q[0] ? {1'b0, opnd_q} : (WIDTH+1)'(0));
    mul_hi_n = mul_sum[WIDTH:1];
    mul_lo_n = {mul_sum[0], mc_lo_q[WIDTH-1:1]};
  end

`ifdef ALU_MC_DIV_EN
  // One restoring-division iteration: hi is the partial remainder, lo shifts dividend out / quotient in.
  logic [WIDTH:0]   div_trial;
  logic             div_fit;
  logic [WIDTH-1:0] div_hi_n, div_lo_n;

  always_comb begin : div_step
    div_trial = {mc_hi_q, mc_lo_q[WIDTH-1]};
    div_fit   = div_trial >= {1'b0, opnd_q};
    div_hi_n  = div_fit ? WIDTH'(div_trial - {1'b0, opnd_q}) : div_trial[WIDTH-1:0];
    div_lo_n  = {mc_lo_q[WIDTH-2:0], div_fit};
  end
`endif

  logic             op_mul, op_div, op_mc;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic             mc_c, mc_v;

  always_comb begin : mc_select
    op_mul  = (i_ctrl == OP_MULU);
    op_div  = 1'b0;
    step_hi = mul_hi_n;
    step_lo = mul_lo_n;
    mc_c    = (mul_hi_n != '0);
    mc_v    = (mul_hi_n != '0);
`ifdef ALU_MC_DIV_EN
    op_div  = (i_ctrl == OP_DIVU);
    if (is_div_q) begin
      step_hi = div_hi_n;
      step_lo = div_lo_n;
      mc_c    = 1'b0;
      mc_v    = (opnd_q == '0);
    end
`endif
  end

  assign op_mc   = op_mul | op_div;
  assign o_ready = i_rst_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && i_ready));
  assign accept  = i_valid && o_ready;

  // Next-state logic; an accept overrides the DONE->IDLE retire for back-to-back issue.
  always_comb begin : fsm_next
    state_d   = state_q;
    cnt_d     = cnt_q;
    opnd_d    = opnd_q;
    mc_hi_d   = mc_hi_q;
    mc_lo_d   = mc_lo_q;
    data_d    = data_q;
    data_hi_d = data_hi_q;
    flag_d    = flag_q;
    valid_d   = valid_q;
`ifdef ALU_MC_DIV_EN
    is_div_d  = is_div_q;
`endif
    case (state_q)
      ST_BUSY: begin
        mc_hi_d = step_hi;
        mc_lo_d = step_lo;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d   = ST_DONE;
          valid_d   = 1'b1;
          cnt_d     = '0;
          data_d    = step_lo;
          data_hi_d = step_hi;
          flag_d    = {mc_c, step_lo[WIDTH-1], mc_v, (step_lo == '0)};
        end
      end
      ST_DONE: begin
        if (i_ready) begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (accept) begin
      if (op_mc) begin
        state_d  = ST_BUSY;
        valid_d  = 1'b0;
        cnt_d    = '0;
        mc_hi_d  = '0;
        mc_lo_d  = op_mul ? i_data_b : i_data_a;
        opnd_d   = op_mul ? i_data_a : i_data_b;
`ifdef ALU_MC_DIV_EN
        is_div_d = op_div;
`endif
      end else begin
        state_d   = ST_DONE;
        valid_d   = 1'b1;
        data_d    = sc_res;
        data_hi_d = '0;
        flag_d    = {sc_c, sc_res[WIDTH-1], sc_v, (sc_res == '0)};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin : regs
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      opnd_q    <= '0;
      mc_hi_q   <= '0;
      mc_lo_q   <= '0;
      data_q    <= '0;
      data_hi_q <= '0;
      flag_q    <= '0;
      valid_q   <= 1'b0;
`ifdef ALU_MC_DIV_EN
      is_div_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opnd_q    <= opnd_d;
      mc_hi_q   <= mc_hi_d;
      mc_lo_q   <= mc_lo_d;
      data_q    <= data_d;
      data_hi_q <= data_hi_d;
      flag_q    <= flag_d;
      valid_q   <= valid_d;
`ifdef ALU_MC_DIV_EN
      is_div_q  <= is_div_d;
`endif
    end
  end

  assign o_valid   = valid_q;
  assign o_data    = data_q;
  assign o_data_hi = data_hi_q;
  assign o_flag    = flag_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=16; flags are {C,S,V,Z}.
// DIVU expectations follow ALU_MC_DIV_EN when the bench is built with the same define.

module tb_alu_mc;

  localparam int unsigned WIDTH = 16;

  localparam logic [5:0] OP_ADD  = 6'h0A;
  localparam logic [5:0] OP_SUB  = 6'h09;
  localparam logic [5:0] OP_INC  = 6'h1B;
  localparam logic [5:0] OP_DEC  = 6'h08;
  localparam logic [5:0] OP_AND  = 6'h06;
  localparam logic [5:0] OP_OR   = 6'h12;
  localparam logic [5:0] OP_NOT  = 6'h14;
  localparam logic [5:0] OP_XOR  = 6'h16;
  localparam logic [5:0] OP_SHL  = 6'h20;
  localparam logic [5:0] OP_SHR  = 6'h30;
  localparam logic [5:0] OP_SAL  = 6'h24;
  localparam logic [5:0] OP_SAR  = 6'h34;
  localparam logic [5:0] OP_ROL  = 6'h22;
  localparam logic [5:0] OP_ROR  = 6'h32;
  localparam logic [5:0] OP_ADC  = 6'h0B;
  localparam logic [5:0] OP_SBB  = 6'h0D;
  localparam logic [5:0] OP_MULU = 6'h0C;
  localparam logic [5:0] OP_DIVU = 6'h0E;

  typedef struct {
    logic [5:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  fl;
    int          lat;
  } vec_t;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [5:0]  i_ctrl = '0;
  logic [15:0] i_data_a = '0;
  logic [15:0] i_data_b = '0;
  logic        i_carry = 1'b0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [15:0] o_data;
  logic [15:0] o_data_hi;
  logic [3:0]  o_flag;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  alu_mc #(.WIDTH(WIDTH)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_ctrl    (i_ctrl),
    .i_data_a  (i_data_a),
    .i_data_b  (i_data_b),
    .i_carry   (i_carry),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_data_hi (o_data_hi),
    .o_flag    (o_flag)
  );

  // Issue one request from IDLE at a negedge; returns edges from accept to first o_valid (1 = next cycle).
  task automatic run_op(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, output int lat);
    i_ctrl   = op;
    i_data_a = a;
    i_data_b = b;
    i_carry  = cin;
    i_valid  = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 64) begin
      @(negedge i_clk);
      lat++;
    end
  endtask

  task automatic drain();
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 i_rst_n = 1'b0;
    #2;
    n_checks++;
    if (o_ready !== 1'b0 || o_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_hs: ready=%b valid=%b required 0 0", o_ready, o_valid);
    end
    n_checks++;
    if (o_data !== 16'h0 || o_data_hi !== 16'h0 || o_flag !== 4'h0) begin
      n_errors++;
      $display("FAIL reset_out: data=%h hi=%h flag=%b required 0", o_data, o_data_hi, o_flag);
    end
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_release: ready=%b valid=%b required 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_add();
    int lat;
    run_op(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, lat);
    n_checks++;
    if (lat !== 1) begin
      n_errors++;
      $display("FAIL add_latency: got %0d required 1", lat);
    end
    n_checks++;
    if (o_data !== 16'h8000 || o_flag !== 4'b0110 || o_data_hi !== 16'h0) begin
      n_errors++;
      $display("FAIL add_result: data=%h hi=%h flag=%b required 8000 0000 0110", o_data, o_data_hi, o_flag);
    end
    drain();
  endtask

  task automatic test_adc();
    int lat;
    run_op(OP_ADC, 16'hFFFF, 16'h0000, 1'b1, lat);
    n_checks++;
    if (lat !== 1 || o_data !== 16'h0000 || o_flag !== 4'b1001) begin
      n_errors++;
      $display("FAIL adc_result: lat=%0d data=%h flag=%b required 1 0000 1001", lat, o_data, o_flag);
    end
    drain();
  endtask

  task automatic test_single_ops();
    vec_t tbl[$];
    int lat;
    tbl.push_back('{OP_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 16'h0, 4'b1100, 1});
    tbl.push_back('{OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 16'h0, 4'b0010, 1});
    tbl.push_back('{OP_INC, 16'hFFFF, 16'h1234, 1'b0, 16'h0000, 16'h0, 4'b1001, 1});
    tbl.push_back('{OP_INC, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 16'h0, 4'b0110, 1});
    tbl.push_back('{OP_DEC, 16'h0000, 16'h0000, 1'b0, 16'hFFFF, 16'h0, 4'b1100, 1});
    tbl.push_back('{OP_SBB, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 16'h0, 4'b1100, 1});
    tbl.push_back('{OP_AND, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 16'h0, 4'b0000, 1});
    tbl.push_back('{OP_OR,  16'h0000, 16'h0000, 1'b1, 16'h0000, 16'h0, 4'b0001, 1});
    tbl.push_back('{OP_NOT, 16'h00FF, 16'h0000, 1'b0, 16'hFF00, 16'h0, 4'b0100, 1});
    tbl.push_back('{OP_XOR, 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 16'h0, 4'b0100, 1});
    tbl.push_back('{OP_SHL, 16'h8001, 16'h0000, 1'b0, 16'h0002, 16'h0, 4'b1000, 1});
    tbl.push_back('{OP_SHR, 16'h8001, 16'h0000, 1'b0, 16'h4000, 16'h0, 4'b1000, 1});
    tbl.push_back('{OP_SAL, 16'h4000, 16'h0000, 1'b0, 16'h8000, 16'h0, 4'b0110, 1});
    tbl.push_back('{OP_SAR, 16'h8002, 16'h0000, 1'b0, 16'hC001, 16'h0, 4'b0100, 1});
    tbl.push_back('{OP_ROL, 16'h8001, 16'h0000, 1'b0, 16'h0003, 16'h0, 4'b1000, 1});
    tbl.push_back('{OP_ROR, 16'h0001, 16'h0000, 1'b0, 16'h8000, 16'h0, 4'b1100, 1});
    tbl.push_back('{6'h3F,  16'h1234, 16'h5678, 1'b1, 16'h1234, 16'h0, 4'b0000, 1});
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, lat);
      n_checks++;
      if (lat !== tbl[i].lat || o_data !== tbl[i].res || o_data_hi !== tbl[i].hi || o_flag !== tbl[i].fl) begin
        n_errors++;
        $display("FAIL single_op_%h: lat=%0d data=%h hi=%h flag=%b required %0d %h %h %b",
                 tbl[i].op, lat, o_data, o_data_hi, o_flag, tbl[i].lat, tbl[i].res, tbl[i].hi, tbl[i].fl);
      end
      drain();
    end
  endtask

  task automatic test_mulu();
    vec_t tbl[$];
    int lat;
    tbl.push_back('{OP_MULU, 16'h0100, 16'h0100, 1'b0, 16'h0000, 16'h0001, 4'b1011, 17});
    tbl.push_back('{OP_MULU, 16'h00FF, 16'h00FF, 1'b0, 16'hFE01, 16'h0000, 4'b0100, 17});
    tbl.push_back('{OP_MULU, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'hFFFE, 4'b1010, 17});
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, lat);
      n_checks++;
      if (lat !== tbl[i].lat || o_data !== tbl[i].res || o_data_hi !== tbl[i].hi || o_flag !== tbl[i].fl) begin
        n_errors++;
        $display("FAIL mulu_%h_%h: lat=%0d data=%h hi=%h flag=%b required %0d %h %h %b",
                 tbl[i].a, tbl[i].b, lat, o_data, o_data_hi, o_flag, tbl[i].lat, tbl[i].res, tbl[i].hi, tbl[i].fl);
      end
      drain();
    end
  endtask

  task automatic test_divu();
    vec_t tbl[$];
    int lat;
`ifdef ALU_MC_DIV_EN
    tbl.push_back('{OP_DIVU, 16'h0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 4'b0000, 17});
    tbl.push_back('{OP_DIVU, 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 4'b0110, 17});
`else
    tbl.push_back('{OP_DIVU, 16'h0064, 16'h0007, 1'b0, 16'h0064, 16'h0000, 4'b0000, 1});
`endif
    foreach (tbl[i]) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].cin, lat);
      n_checks++;
      if (lat !== tbl[i].lat || o_data !== tbl[i].res || o_data_hi !== tbl[i].hi || o_flag !== tbl[i].fl) begin
        n_errors++;
        $display("FAIL divu_%h_%h: lat=%0d data=%h hi=%h flag=%b required %0d %h %h %b",
                 tbl[i].a, tbl[i].b, lat, o_data, o_data_hi, o_flag, tbl[i].lat, tbl[i].res, tbl[i].hi, tbl[i].fl);
      end
      drain();
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    i_ctrl   = OP_MULU;
    i_data_a = 16'h0002;
    i_data_b = 16'h0003;
    i_valid  = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_ctrl   = OP_ADD;
    i_data_a = 16'h1111;
    i_data_b = 16'h0001;
    n_checks++;
    if (o_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL busy_ready: got %b required 0", o_ready);
    end
    lat = 1;
    while (o_valid !== 1'b1 && lat < 64) begin
      @(negedge i_clk);
      lat++;
    end
    n_checks++;
    if (lat !== 17 || o_data !== 16'h0006 || o_data_hi !== 16'h0000) begin
      n_errors++;
      $display("FAIL busy_ignore: lat=%0d data=%h hi=%h required 17 0006 0000", lat, o_data, o_data_hi);
    end
    i_valid = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(OP_MULU, 16'h0003, 16'h0005, 1'b0, lat);
    n_checks++;
    if (lat !== 17 || o_data !== 16'h000F) begin
      n_errors++;
      $display("FAIL hold_first: lat=%0d data=%h required 17 000F", lat, o_data);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      n_checks++;
      if (o_valid !== 1'b1 || o_data !== 16'h000F || o_flag !== 4'b0000 || o_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL hold_cycle%0d: valid=%b data=%h flag=%b ready=%b required 1 000F 0000 0",
                 c, o_valid, o_data, o_flag, o_ready);
      end
    end
    i_ctrl   = OP_ADD;
    i_data_a = 16'h0001;
    i_data_b = 16'h0002;
    i_valid  = 1'b1;
    i_ready  = 1'b1;
    #1;
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_ready: got %b required 1", o_ready);
    end
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_ready = 1'b0;
    n_checks++;
    if (o_valid !== 1'b1 || o_data !== 16'h0003 || o_flag !== 4'b0000) begin
      n_errors++;
      $display("FAIL b2b_result: valid=%b data=%h flag=%b required 1 0003 0000", o_valid, o_data, o_flag);
    end
    drain();
  endtask

  task automatic test_reset_mid_mulu();
    logic seen_valid;
    i_ctrl   = OP_MULU;
    i_data_a = 16'h0100;
    i_data_b = 16'h0100;
    i_valid  = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (7) @(negedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_data !== 16'h0 || o_data_hi !== 16'h0 || o_flag !== 4'h0) begin
      n_errors++;
      $display("FAIL abort_outputs: valid=%b ready=%b data=%h hi=%h flag=%b required all 0",
               o_valid, o_ready, o_data, o_data_hi, o_flag);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    n_checks++;
    if (o_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_ready: got %b required 1", o_ready);
    end
    seen_valid = 1'b0;
    repeat (24) begin
      @(negedge i_clk);
      if (o_valid !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL abort_no_result: o_valid pulsed=%b required 0", seen_valid);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_adc();
    test_single_ops();
    test_mulu();
    test_divu();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid_mulu();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter WIDTH, default 16: datapath width in bits; legal range 8..64.
REQ-002 i_clk  input  1  the block's single clock; all state changes on its rising edge.
REQ-003 i_rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 i_valid  input  1  operation request.
REQ-005 o_ready  output  1  block can accept a request this cycle.
REQ-006 i_ctrl  input  6  opcode.
REQ-007 i_data_a, i_data_b  input  WIDTH  operands.
REQ-008 i_carry  input  1  carry-in for ADC/SBB.
REQ-009 o_valid  output  1  result available.
REQ-010 i_ready  input  1  consumer accepts the result.
REQ-011 o_data  output  WIDTH  primary result: sum, low product or quotient.
REQ-012 o_data_hi  output  WIDTH  secondary result: high product or remainder; zero for other ops.
REQ-013 o_flag  output  4  {C,S,V,Z}, registered with o_data.

Function
REQ-014 Single-cycle ops SHALL use these opcodes:
- ADD 0A, SUB 09, INC 1B, DEC 08
- AND 06, OR 12, NOT 14, XOR 16
- SHL 20, SHR 30, SAL 24, SAR 34, ROL 22, ROR 32
- ADC 0B (a+b+i_carry), SBB 0D (a-b-i_carry)
- any undefined opcode SHALL pass a through.
REQ-015 Multi-cycle ops SHALL use these opcodes: MULU 0C (unsigned shift-add), DIVU 0E (restoring, unsigned).
REQ-016 The FSM SHALL have states IDLE, BUSY and DONE.
REQ-017 o_ready SHALL be 1 in IDLE, and 1 in DONE when i_ready=1; it SHALL be 0 otherwise.
REQ-018 A request SHALL be accepted on the edge where i_valid=1 and o_ready=1; operands and opcode are captured on that edge.
REQ-019 For a single-cycle op, the result SHALL be registered on the accept edge, the FSM SHALL go to DONE, and o_valid SHALL be 1 the next cycle (latency 1).
REQ-020 For a multi-cycle op, the FSM SHALL go to BUSY, step an iteration counter 0..WIDTH-1, and enter DONE after WIDTH BUSY cycles (o_valid first high WIDTH+1 cycles after accept).
REQ-021 In DONE, o_valid=1 and o_data, o_data_hi and o_flag SHALL be held stable until i_ready=1.
REQ-022 On that edge the FSM SHALL go to IDLE, or accept a simultaneous new request directly (back-to-back, no bubble).
REQ-023 i_valid SHALL be ignored in BUSY; no request is lost because o_ready=0 in BUSY.
REQ-024 Arithmetic SHALL be computed at WIDTH+1 bits; C is bit WIDTH (borrow for SUB/DEC/SBB).
REQ-025 C for shifts and rotates SHALL be the bit shifted out.
REQ-026 C SHALL be 0 for logic ops.
REQ-027 V SHALL be the signed overflow for ADD/SUB/INC/DEC/ADC/SBB.
REQ-028 V SHALL be 1 for SAL when the sign bit changes.
REQ-029 V SHALL be 0 for all other single-cycle ops.
REQ-030 MULU: o_data/o_data_hi = low/high product; C=V=(high!=0).
REQ-031 DIVU: o_data = quotient, o_data_hi = remainder.
REQ-032 DIVU by zero: quotient all-ones, remainder = a, V=1, C=0; it SHALL still take WIDTH cycles.
REQ-033 S SHALL be o_data[WIDTH-1].
REQ-034 Z SHALL be (o_data==0).

Reset
REQ-035 While i_rst_n=0, asynchronously: FSM SHALL be IDLE; o_valid=0; o_data, o_data_hi, o_flag and the counter SHALL be 0.
REQ-036 o_ready SHALL be 0 during reset and 1 from the first cycle after release.
REQ-037 Reset during BUSY or DONE SHALL discard the operation without emitting a result.

Configuration
REQ-038 Macro ALU_MC_DIV_EN: defined, DIVU SHALL be implemented per REQ-031/032.
REQ-039 With ALU_MC_DIV_EN undefined, no divider logic SHALL exist and opcode 0E SHALL be treated as undefined (single-cycle pass-through of a, o_data_hi=0).
REQ-040 MULU SHALL be present in both builds.

Verification (WIDTH=16)
REQ-041 ADD a=7FFF b=0001 -> o_data=8000, o_flag=0110, o_valid one cycle after accept.
REQ-042 ADC a=FFFF b=0000 i_carry=1 -> o_data=0000, o_flag=1001.
REQ-043 MULU a=0100 b=0100 -> o_data=0000, o_data_hi=0001, o_flag=1011, o_valid 17 cycles after accept.
REQ-044 DIVU a=0064 b=0007 -> o_data=000E, o_data_hi=0002; DIVU a=1234 b=0000 -> o_data=FFFF, o_data_hi=1234, V=1; with macro off, 0E -> o_data=0064, latency 1.
REQ-045 Hold i_ready=0 for 5 cycles in DONE -> o_valid, o_data and o_flag stable, o_ready=0; raise i_ready with i_valid=1 -> next op accepted on the same edge.
REQ-046 Assert i_rst_n=0 mid-MULU (cycle 8) -> all outputs 0 immediately; after release o_ready=1 and o_valid never pulses for the aborted op.
